// File: rtl/inst_mem_resp_pkg.sv
// inst_mem_resp_pkg: shared response type, NOP encoding and error bit positions.
package inst_mem_resp_pkg;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int ERR_MIS = 0;
  localparam int ERR_RANGE = 1;
  typedef struct packed {
    logic        valid;
    logic [1:0]  err;
    logic [31:0] data;
  } resp_t;
  localparam resp_t RESP_RST = '{valid: 1'b0, err: 2'b00, data: INST_NOP};
  function automatic resp_t advance(resp_t nxt, resp_t cur);
    return '{valid: nxt.valid, err: nxt.valid ? nxt.err : cur.err, data: nxt.valid ? nxt.data : cur.data};
  endfunction
endpackage

// File: rtl/inst_mem_pipe.sv
// inst_mem_pipe: STAGES-deep response delay line; bubbles keep the last err/data.
module inst_mem_pipe
  import inst_mem_resp_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  resp_t head,
  output resp_t tail
);
  resp_t q [STAGES];
  always_ff @(posedge clk) begin
    q[0] <= rst ? RESP_RST : advance(head, q[0]);
    for (int k = 1; k < STAGES; k++) q[k] <= rst ? RESP_RST : advance(q[k-1], q[k]);
  end
  assign tail = q[STAGES-1];
endmodule

// File: rtl/inst_mem_resp.sv
// inst_mem_resp: pipelined instruction-memory responder with a side load port.
// Optional INST_MEM_PERF_EN adds fetch_cnt/err_cnt counters.
module inst_mem_resp
  import inst_mem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int          READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ena,
  input  logic [63:0] inst_addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [1:0]  fetch_err,
  input  logic        load_ena,
  input  logic [63:0] load_addr,
  input  logic [31:0] load_data
`ifdef INST_MEM_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] err_cnt
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 2;
  logic [31:0] mem [DEPTH_WORDS];
  logic [63:0] off, loff;
  logic [1:0]  err;
  resp_t req, s1, resp;
  assign off = inst_addr - BASE_ADDR;
  assign loff = load_addr - BASE_ADDR;
  assign err[ERR_MIS] = inst_addr[1:0] != 2'b00;
  assign err[ERR_RANGE] = off >= SPAN;
  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test.
  always_ff @(posedge clk)
    if (load_ena && !rst && loff < SPAN && load_addr[1:0] == 2'b00) mem[loff[AW+1:2]] <= load_data;
  assign req = '{valid: inst_ena, err: err, data: (|err) ? INST_NOP : mem[off[AW+1:2]]};
  always_ff @(posedge clk) s1 <= rst ? RESP_RST : advance(req, s1);
  if (READ_LAT > 1) begin : g_dly
    inst_mem_pipe #(.STAGES(READ_LAT - 1)) u_pipe (.clk(clk), .rst(rst), .head(s1), .tail(resp));
  end else begin : g_nodly
    assign resp = s1;
  end
  assign inst = resp.data;
  assign inst_valid = resp.valid;
  assign fetch_err = resp.err;
`ifdef INST_MEM_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      err_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(inst_ena);
      err_cnt <= err_cnt + 32'(inst_valid && |fetch_err);
    end
  end
`endif
endmodule

// File: tb/tb_inst_mem_resp.sv
// tb_inst_mem_resp: directed self-checking bench for inst_mem_resp (READ_LAT=3).
module tb_inst_mem_resp;
  localparam int LAT = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] B = 64'h8000_0000;
  logic clk = 0, rst = 1, inst_ena = 0, load_ena = 0;
  logic [63:0] inst_addr = '0, load_addr = '0;
  logic [31:0] load_data = '0, inst;
  logic inst_valid;
  logic [1:0] fetch_err;
`ifdef INST_MEM_PERF_EN
  logic [31:0] fetch_cnt, err_cnt;
`endif
  typedef struct {
    logic v;
    logic [1:0] e;
    logic [31:0] i;
  } exp_t;
  exp_t hist [$];
  logic [31:0] last_i = NOP;
  logic [1:0] last_e = 2'b00;
  string cur = "reset";
  int checks = 0, errors = 0;

  inst_mem_resp #(.DEPTH_WORDS(4096), .BASE_ADDR(B), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .inst_ena(inst_ena), .inst_addr(inst_addr), .inst(inst),
    .inst_valid(inst_valid), .fetch_err(fetch_err), .load_ena(load_ena),
    .load_addr(load_addr), .load_data(load_data)
`ifdef INST_MEM_PERF_EN
    , .fetch_cnt(fetch_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s got=%h exp=%h", cur, tag, got, exp);
    end
  endtask

  // One cycle of stimulus; the response issued LAT cycles earlier is checked.
  task automatic step(logic ena, logic [63:0] addr, logic [31:0] ei = NOP, logic [1:0] ee = 2'b00);
    exp_t x;
    if (ena) begin
      last_i = ei;
      last_e = ee;
    end
    hist.push_back('{ena, last_e, last_i});
    inst_ena = ena;
    inst_addr = addr;
    @(posedge clk);
    #1;
    if (hist.size() == LAT) begin
      x = hist.pop_front();
      chk("valid", 64'(inst_valid), 64'(x.v));
      chk("inst", 64'(inst), 64'(x.i));
      chk("err", 64'(fetch_err), 64'(x.e));
    end
  endtask

  task automatic ld(logic [63:0] a, logic [31:0] d);
    load_ena = 1;
    load_addr = a;
    load_data = d;
    step(0, '0);
    load_ena = 0;
  endtask

  task automatic flush();
    repeat (LAT) step(0, '0);
  endtask

  // One-cycle reset with a fetch and a load presented that must both be ignored.
  task automatic do_rst(logic [63:0] fa, logic [63:0] la, logic [31:0] ld_val);
    rst = 1;
    inst_ena = 1;
    inst_addr = fa;
    load_ena = 1;
    load_addr = la;
    load_data = ld_val;
    @(posedge clk);
    #1;
    rst = 0;
    inst_ena = 0;
    load_ena = 0;
    hist.delete();
    last_i = NOP;
    last_e = 2'b00;
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'(NOP));
    chk("rst_err", 64'(fetch_err), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("valid", 64'(inst_valid), 64'd0);
    chk("inst", 64'(inst), 64'(NOP));
    chk("err", 64'(fetch_err), 64'd0);
    rst = 0;
    cur = "load";
    ld(B + 0, 32'h0010_0093);
    ld(B + 4, 32'h0020_0113);
    ld(B + 8, 32'h0020_81b3);
    ld(B + 12, 32'h0000_0013);
    ld(B + 20, 32'hAAAA_AAAA);
    ld(B + 64'h3FFC, 32'hDEAD_BEEF);
    ld(B + 6, 32'h1234_5678);
    ld(B + 64'h4000, 32'hFFFF_FFFF);
    cur = "t1_stream";
    step(1, B + 0, 32'h0010_0093);
    step(1, B + 4, 32'h0020_0113);
    step(1, B + 8, 32'h0020_81b3);
    step(1, B + 12, 32'h0000_0013);
    step(1, B + 64'h3FFC, 32'hDEAD_BEEF);
    cur = "t2_err";
    step(1, B + 2, NOP, 2'b01);
    step(1, 64'h7FFF_FFFC, NOP, 2'b10);
    step(1, B + 64'h4000, NOP, 2'b10);
    step(1, 64'h7FFF_FFFE, NOP, 2'b11);
    cur = "t3_bubble";
    step(1, B + 0, 32'h0010_0093);
    step(0, B + 4);
    step(1, B + 4, 32'h0020_0113);
    step(0, B + 8);
    step(1, B + 8, 32'h0020_81b3);
    step(0, '0);
    step(1, B + 64'h3FFC, 32'hDEAD_BEEF);
    step(0, '0);
    cur = "t4_rbw";
    load_ena = 1;
    load_addr = B + 20;
    load_data = 32'h5555_5555;
    step(1, B + 20, 32'hAAAA_AAAA);
    load_ena = 0;
    step(1, B + 20, 32'h5555_5555);
    flush();
    cur = "t5_rst";
    step(1, B + 4, 32'h0020_0113);
    step(1, B + 8, 32'h0020_81b3);
    do_rst(B + 12, B + 0, 32'hFFFF_FFFF);
    step(0, '0);
    chk("post_valid", 64'(inst_valid), 64'd0);
    chk("post_inst", 64'(inst), 64'(NOP));
    step(1, B + 0, 32'h0010_0093);
    step(0, '0);
    flush();
`ifdef INST_MEM_PERF_EN
    cur = "t6_perf";
    do_rst('0, '0, '0);
    chk("fetch_cnt0", 64'(fetch_cnt), 64'd0);
    chk("err_cnt0", 64'(err_cnt), 64'd0);
    for (int k = 0; k < 8; k++) step(1, B + 64'((k % 4) * 4), k % 4 == 0 ? 32'h0010_0093 : k % 4 == 1 ? 32'h0020_0113 : k % 4 == 2 ? 32'h0020_81b3 : 32'h0000_0013);
    step(1, B + 1, NOP, 2'b01);
    step(1, B + 3, NOP, 2'b01);
    flush();
    chk("fetch_cnt", 64'(fetch_cnt), 64'd10);
    chk("err_cnt", 64'(err_cnt), 64'd2);
    do_rst('0, '0, '0);
    chk("fetch_cnt_rst", 64'(fetch_cnt), 64'd0);
    chk("err_cnt_rst", 64'(err_cnt), 64'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
